// File: rtl/fill_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fill_arbiter_pkg
//  Description : Shared constants and types for the DRAM-cache fill arbiter.
//                - Default AXI and cache geometry.
//                - FSM state encodings.
//                - Tag-word bit positions.
//                - AXI response code.
//  Revision    : 1.0 - initial release
// ============================================================================
package fill_arbiter_pkg;

    // Default geometry. A 32-bit address splits into:
    //   tag    : 16 bits [31:16]
    //   index  : 10 bits [15:6]
    //   offset :  6 bits [5:0]
    localparam int c_AXI_ADDR_WIDTH = 32;
    localparam int c_AXI_DATA_WIDTH = 32;
    localparam int c_AXI_ID_WIDTH   = 4;
    localparam int c_TAG_WIDTH      = 16;
    localparam int c_BLANK_WIDTH    = 2;
    localparam int c_TAG_SIZE       = 2 + c_TAG_WIDTH + c_BLANK_WIDTH;
    localparam int c_INDEX_WIDTH    = 10;
    localparam int c_OFFSET_WIDTH   = 6;

    // FSM encodings
    localparam logic [0:0] c_S_IDLE_ENC  = 1'b0;
    localparam logic [0:0] c_S_ISSUE_ENC = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE  = c_S_IDLE_ENC,
        S_ISSUE = c_S_ISSUE_ENC
    } state_t;

    // Tag word layout, MSB first: {VALID, DIRTY, TAG, BLANK}
    localparam int c_VALID_BIT = c_TAG_SIZE - 1;
    localparam int c_DIRTY_BIT = c_TAG_SIZE - 2;

    localparam logic [1:0] c_AXI_RESP_OKAY = 2'b00;

endpackage : fill_arbiter_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin arbiter.
//                - The priority pointer moves to the requester that was not
//                  served, but only when a grant is actually accepted.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                i_req[1:0] - request vector (bit 0 = fill, bit 1 = refill)
//                i_accept   - the current grant was taken this cycle
//                o_grant    - one-hot (or zero) grant vector
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // 0: requester 0 has priority; 1: requester 1 has priority
    logic r_ptr_q;
    logic w_ptr_d;

    always_comb begin
        o_grant = i_req;
        if (i_req[0] && i_req[1]) begin
            o_grant = r_ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After serving requester 0 the pointer favours 1, and vice versa.
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (i_accept) begin
            w_ptr_d = o_grant[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= 1'b0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fill_arbiter
//  Description : Merges dirty fills (from the tag comparator) and clean
//                refills (from main memory) into single-beat AXI writes to
//                the DRAM-cache controller. The inline tag word is built
//                above the data line. Writes awaiting a B response are
//                counted.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                fill_*   valid/ready/data - dirty write source {addr,data}
//                refill_* valid/ready/data - clean refill source {addr,data}
//                aw*, w*, b*              - AXI write channels (single beat)
//                busy_o                   - issuing, or writes outstanding
//                err_o                    - sticky error: non-OKAY or
//                                           unexpected B response
//  Revision    : 1.0 - initial release
// ============================================================================
module fill_arbiter
    import fill_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = c_AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH      = c_AXI_DATA_WIDTH,
    parameter int ID_WIDTH        = c_AXI_ID_WIDTH,
    parameter int TAG_SIZE        = c_TAG_SIZE,
    parameter int TAG_WIDTH       = c_TAG_WIDTH,
    parameter int BLANK_WIDTH     = c_BLANK_WIDTH,
    parameter int INDEX_WIDTH     = c_INDEX_WIDTH,
    parameter int OFFSET_WIDTH    = c_OFFSET_WIDTH,
    parameter int AWID            = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fill_valid_i,
    output logic                           fill_ready_o,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i,
    input  logic                           refill_valid_i,
    output logic                           refill_ready_o,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i,
    output logic [ID_WIDTH-1:0]            awid_o,
    output logic [ADDR_WIDTH-1:0]          awaddr_o,
    output logic                           awvalid_o,
    input  logic                           awready_i,
    output logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_o,
    output logic                           wlast_o,
    output logic                           wvalid_o,
    input  logic                           wready_i,
    input  logic [ID_WIDTH-1:0]            bid_i,
    input  logic [1:0]                     bresp_i,
    input  logic                           bvalid_i,
    output logic                           bready_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int c_CNT_W    = $clog2(MAX_OUTSTANDING) + 1;
    localparam int c_LINE_LSB = INDEX_WIDTH + OFFSET_WIDTH;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                          r_state_q,       w_state_d;
    logic [ADDR_WIDTH-1:0]           r_awaddr_q,      w_awaddr_d;
    logic [TAG_SIZE+DATA_WIDTH-1:0]  r_wdata_q,       w_wdata_d;
    logic                            r_aw_done_q,     w_aw_done_d;
    logic                            r_w_done_q,      w_w_done_d;
    logic [c_CNT_W-1:0]              r_outstanding_q, w_outstanding_d;
    logic                            r_err_q,         w_err_d;

    // ------------------------------------------------------------------
    // Arbitration and source selection
    // ------------------------------------------------------------------
    logic [1:0]                      w_grant;
    logic                            w_eligible;
    logic                            w_idle;
    logic                            w_accept;
    logic                            w_sel_refill;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] w_src;
    logic [ADDR_WIDTH-1:0]           w_src_addr;
    logic [DATA_WIDTH-1:0]           w_src_data;
    logic [TAG_SIZE-1:0]             w_tag_word;
    logic                            w_aw_hs;
    logic                            w_w_hs;
    logic                            w_b_hs;

    assign w_idle     = (r_state_q == S_IDLE);
    assign w_eligible = (r_outstanding_q < c_CNT_W'(MAX_OUTSTANDING));

    rr_arbiter2 u_rr_arbiter2 (
        .clk      (clk),
        .rst      (rst),
        .i_req    ({refill_valid_i, fill_valid_i}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign fill_ready_o   = w_idle && w_eligible && w_grant[0];
    assign refill_ready_o = w_idle && w_eligible && w_grant[1];
    assign w_accept       = (fill_ready_o && fill_valid_i) ||
                            (refill_ready_o && refill_valid_i);

    assign w_sel_refill = w_grant[1];
    assign w_src        = w_sel_refill ? refill_data_i : fill_data_i;
    assign w_src_addr   = w_src[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign w_src_data   = w_src[DATA_WIDTH-1:0];

    // Fills carry modified data (dirty); refills are clean copies.
    assign w_tag_word = {1'b1, ~w_sel_refill,
                         w_src_addr[ADDR_WIDTH-1:c_LINE_LSB],
                         {BLANK_WIDTH{1'b0}}};

    // ------------------------------------------------------------------
    // AXI handshakes
    // ------------------------------------------------------------------
    assign awvalid_o = (r_state_q == S_ISSUE) && !r_aw_done_q;
    assign wvalid_o  = (r_state_q == S_ISSUE) && !r_w_done_q;
    assign w_aw_hs   = awvalid_o && awready_i;
    assign w_w_hs    = wvalid_o && wready_i;
    assign w_b_hs    = bvalid_i && bready_o;

    assign awid_o   = ID_WIDTH'(AWID);
    assign awaddr_o = r_awaddr_q;
    assign wdata_o  = r_wdata_q;
    assign wlast_o  = 1'b1;
    assign bready_o = 1'b1;
    assign busy_o   = !w_idle || (r_outstanding_q != '0);
    assign err_o    = r_err_q;

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state_q;
        w_awaddr_d  = r_awaddr_q;
        w_wdata_d   = r_wdata_q;
        w_aw_done_d = r_aw_done_q;
        w_w_done_d  = r_w_done_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_accept) begin
                    // Keep only the set index: the line lives at its set slot.
                    w_awaddr_d  = {{(ADDR_WIDTH-c_LINE_LSB){1'b0}},
                                   w_src_addr[c_LINE_LSB-1:OFFSET_WIDTH],
                                   {OFFSET_WIDTH{1'b0}}};
                    w_wdata_d   = {w_tag_word, w_src_data};
                    w_aw_done_d = 1'b0;
                    w_w_done_d  = 1'b0;
                    w_state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_aw_hs) begin
                    w_aw_done_d = 1'b1;
                end
                if (w_w_hs) begin
                    w_w_done_d = 1'b1;
                end
                if ((r_aw_done_q || w_aw_hs) && (r_w_done_q || w_w_hs)) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outstanding-write counter and sticky error
    // ------------------------------------------------------------------
    always_comb begin
        w_outstanding_d = r_outstanding_q;
        w_err_d         = r_err_q;
        if (w_b_hs && (bresp_i != c_AXI_RESP_OKAY)) begin
            w_err_d = 1'b1;
        end
        if (w_aw_hs && !w_b_hs) begin
            w_outstanding_d = r_outstanding_q + c_CNT_W'(1);
        end else if (w_b_hs && !w_aw_hs) begin
            // A response with nothing outstanding is flagged, not counted.
            if (r_outstanding_q == '0) begin
                w_err_d = 1'b1;
            end else begin
                w_outstanding_d = r_outstanding_q - c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= S_IDLE;
            r_awaddr_q      <= '0;
            r_wdata_q       <= '0;
            r_aw_done_q     <= 1'b0;
            r_w_done_q      <= 1'b0;
            r_outstanding_q <= '0;
            r_err_q         <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_awaddr_q      <= w_awaddr_d;
            r_wdata_q       <= w_wdata_d;
            r_aw_done_q     <= w_aw_done_d;
            r_w_done_q      <= w_w_done_d;
            r_outstanding_q <= w_outstanding_d;
            r_err_q         <= w_err_d;
        end
    end

    // The B ID is not checked, and the line offset is discarded.
    logic w_unused;
    assign w_unused = ^{bid_i, w_src_addr[OFFSET_WIDTH-1:0]};

endmodule : fill_arbiter
`default_nettype wire

// File: tb/tb_fill_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fill_arbiter
//  Description : Directed self-checking bench for fill_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fill_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int TS = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          fill_valid, fill_ready;
    logic [AW+DW-1:0] fill_data;
    logic          refill_valid, refill_ready;
    logic [AW+DW-1:0] refill_data;
    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic          awvalid, awready;
    logic [TS+DW-1:0] wdata;
    logic          wlast, wvalid, wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic          busy, err;

    always #5 clk = ~clk;

    fill_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TAG_SIZE(TS),
        .TAG_WIDTH(16), .BLANK_WIDTH(2), .INDEX_WIDTH(10), .OFFSET_WIDTH(6),
        .AWID(0), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst(rst),
        .fill_valid_i(fill_valid), .fill_ready_o(fill_ready), .fill_data_i(fill_data),
        .refill_valid_i(refill_valid), .refill_ready_o(refill_ready), .refill_data_i(refill_data),
        .awid_o(awid), .awaddr_o(awaddr), .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
        .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
        .busy_o(busy), .err_o(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Set address: index bits [15:6] only.
    function automatic logic [AW-1:0] exp_awaddr(input logic [AW-1:0] a);
        return a & 32'h0000_FFC0;
    endfunction

    // {valid=1, dirty, tag=a[31:16], blank=2'b00, data}
    function automatic logic [TS+DW-1:0] exp_wdata(input logic [AW-1:0] a,
                                                  input logic [DW-1:0] d,
                                                  input logic dirty);
        return {1'b1, dirty, a[31:16], 2'b00, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Push one fill through with awready=wready=1; returns with DUT idle.
    task automatic push_fill(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        fill_data  = {a, d};
        fill_valid = 1'b1;
        #1;
        k = 0;
        while (!fill_ready && k < 20) begin
            tick();
            #1;
            k++;
        end
        if (k >= 20) chk("push_fill_timeout", fill_ready, 1'b1);
        tick();
        fill_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        logic exp_f;
        logic [AW-1:0] fa, ra;
        logic [DW-1:0] fd, rd;
        logic [TS+DW-1:0] held;

        rst = 1'b1;
        fill_valid = 0; refill_valid = 0; fill_data = '0; refill_data = '0;
        awready = 1; wready = 1; bid = '0; bresp = 2'b00; bvalid = 0;
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_bready", bready, 1);
        chk("rst_wlast", wlast, 1);
        chk("rst_awid", awid, 0);
        rst = 1'b0;
        tick();

        // ---------------- single fill ----------------
        fa = 32'h1234_5680; fd = 32'hA5A5_A5A5;
        fill_data = {fa, fd}; fill_valid = 1;
        #1;
        chk("f1_fill_ready", fill_ready, 1);
        chk("f1_refill_ready", refill_ready, 0);
        tick();
        #1;
        chk("f1_awvalid", awvalid, 1);
        chk("f1_wvalid", wvalid, 1);
        chk("f1_awaddr", awaddr, 32'h0000_5680);
        chk("f1_wdata", wdata, exp_wdata(fa, fd, 1'b1));
        chk("f1_no_ready_in_issue", fill_ready, 0);
        fill_valid = 0;
        tick();
        #1;
        chk("f1_awvalid_done", awvalid, 0);
        chk("f1_wvalid_done", wvalid, 0);
        chk("f1_busy_outstanding", busy, 1);
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        #1;
        chk("f1_busy_clear", busy, 0);
        chk("f1_err_clear", err, 0);

        // ---------------- round robin F,R,F,R ----------------
        rst_pulse();
        fa = 32'h0BAD_F00D; fd = 32'h1111_2222;
        ra = 32'hABCD_1FC7; rd = 32'h3333_4444;
        fill_data = {fa, fd}; refill_data = {ra, rd};
        fill_valid = 1; refill_valid = 1;
        for (int i = 0; i < 4; i++) begin
            exp_f = (i % 2 == 0);
            #1;
            chk($sformatf("rr%0d_fill_ready", i), fill_ready, exp_f);
            chk($sformatf("rr%0d_refill_ready", i), refill_ready, !exp_f);
            tick();
            #1;
            chk($sformatf("rr%0d_awaddr", i), awaddr, exp_awaddr(exp_f ? fa : ra));
            chk($sformatf("rr%0d_wdata", i), wdata,
                exp_f ? exp_wdata(fa, fd, 1'b1) : exp_wdata(ra, rd, 1'b0));
            chk($sformatf("rr%0d_issue_ready", i), fill_ready | refill_ready, 0);
            tick();
        end
        #1;
        chk("rr_full_fill_ready", fill_ready, 0);
        chk("rr_full_refill_ready", refill_ready, 0);
        chk("rr_full_busy", busy, 1);
        fill_valid = 0; refill_valid = 0;
        rst_pulse();

        // ---------------- W back-pressure ----------------
        awready = 1; wready = 0;
        fa = 32'h0F0F_0040; fd = 32'h1357_9BDF;
        fill_data = {fa, fd}; fill_valid = 1;
        #1;
        chk("bp_fill_ready", fill_ready, 1);
        tick();
        #1;
        chk("bp_awvalid", awvalid, 1);
        chk("bp_wvalid", wvalid, 1);
        held = exp_wdata(fa, fd, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("bp%0d_awvalid", i), awvalid, 0);
            chk($sformatf("bp%0d_wvalid", i), wvalid, 1);
            chk($sformatf("bp%0d_wdata", i), wdata, held);
            chk($sformatf("bp%0d_fill_ready", i), fill_ready, 0);
            tick();
        end
        wready = 1;
        #1;
        chk("bp_wvalid_last", wvalid, 1);
        tick();
        #1;
        chk("bp_wvalid_done", wvalid, 0);
        chk("bp_ready_again", fill_ready, 1);
        fill_valid = 0;
        rst_pulse();

        // ---------------- outstanding limit ----------------
        awready = 1; wready = 1; bvalid = 0;
        fill_data = {32'h2222_0080, 32'hCAFE_0001}; fill_valid = 1;
        accepted = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (fill_ready) accepted++;
            tick();
        end
        chk("lim_accepted", accepted, 4);
        #1;
        chk("lim_ready_low", fill_ready, 0);
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        #1;
        chk("lim_fifth_ready", fill_ready, 1);
        tick();
        #1;
        chk("lim_fifth_issue", awvalid, 1);
        fill_valid = 0;
        tick();
        rst_pulse();

        // ---------------- AW+B same cycle, error response ----------------
        push_fill(32'h3000_0100, 32'h0000_0001);
        push_fill(32'h3000_0140, 32'h0000_0002);
        chk("ab_count2", dut.r_outstanding_q, 2);
        fill_data = {32'h3000_0180, 32'h0000_0003}; fill_valid = 1;
        #1;
        chk("ab_ready", fill_ready, 1);
        tick();
        fill_valid = 0;
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        #1;
        chk("ab_count_same", dut.r_outstanding_q, 2);
        chk("ab_err0", err, 0);
        bvalid = 1; bresp = 2'b10;
        tick();
        bvalid = 0; bresp = 2'b00;
        #1;
        chk("err_set", err, 1);
        chk("err_count1", dut.r_outstanding_q, 1);
        tick(); tick(); tick();
        chk("err_sticky", err, 1);

        // ---------------- reset mid-issue ----------------
        push_fill(32'h4000_0200, 32'h0000_0004);
        push_fill(32'h4000_0240, 32'h0000_0005);
        awready = 0; wready = 0;
        fill_data = {32'h4000_0280, 32'h0000_0006}; fill_valid = 1;
        #1;
        tick();
        fill_valid = 0;
        #1;
        chk("mid_awvalid", awvalid, 1);
        chk("mid_count3", dut.r_outstanding_q, 3);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fill_arbiter
`default_nettype wire
